id_stage_hs: RTL and testbench
==============================

// Module: id_stage_hs
// PURPOSE
//   Parametrised decode stage that replaces the flat combinational ID stage. It
//   decodes RV32I instructions, resolves rs2/rd use per instruction format and
//   sign-extends immediates to XLEN. It registers the result into an ID/EX
//   pipeline register with a valid/ready handshake.
//   It adds load-use hazard stalling, branch flush and a saturating stall counter.
// PARAMETERS
//   XLEN       32  data/address path width; imm and pc outputs are XLEN bits
//   REG_ADDR_W 5   register address width
//   ALU_W      4   aluCtr width
//   BR_W       4   branchCtr width
//   CNT_W      16  width of the stall_cnt performance counter
// PORTS
//   clk          in  1          single clock, rising edge
//   rst          in  1          asynchronous, active-low reset
//   in_valid     in  1          IF holds a valid insn/pc
//   in_ready     out 1          ID accepts insn this cycle
//   insn         in  32         instruction word
//   pc           in  XLEN       instruction address
//   flush        in  1          branch mispredict; kill ID contents and incoming insn
//   ex_ld_valid  in  1          EX stage holds a load
//   ex_ld_rd     in  REG_ADDR_W destination of that load
//   out_valid    out 1          ID/EX register holds a valid op
//   out_ready    in  1          EX accepts op this cycle
//   registerWriteEnable, dataWriteEnable, regSelect  out 1 each (regSelect=1: wb from mem)
//   branchCtr    out BR_W       0=none, 1=JAL, 2=JALR, {1'b1,funct3}=Bxx
//   aluCtr       out ALU_W      0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//   regA, regB, rd  out REG_ADDR_W  rs1 / rs2 / rd; 0 when the field is unused by the format
//   offset       out XLEN       sign-extended immediate (I/S/B/U/J per opcode)
//   pc_out       out XLEN       pc of the registered insn
//   illegal      out 1          registered op had an unsupported opcode
//   stall_cnt    out CNT_W      saturating count of load-use stall cycles
// BEHAVIOUR
//   - Reset (rst=0, async): out_valid=0, all control and registered outputs 0, stall_cnt=0.
//   - Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
//   - hazard = in_valid & ex_ld_valid & ex_ld_rd!=0 & (ex_ld_rd==rs1_used | ex_ld_rd==rs2_used).
//   - in_ready = rst & !flush & !hazard & (!out_valid | out_ready).
//   - Accept = in_valid & in_ready: latency 1; decoded fields land on the next edge
//     and the stage goes to or stays FULL.
//   - FULL & out_ready & !accept -> EMPTY. FULL & !out_ready: all outputs hold stable.
//   - Hazard with out_ready (or EMPTY): a bubble is inserted, so out_valid goes 0 next cycle.
//     The insn stays on the IF side and is retried.
//   - flush: next state is EMPTY regardless of accept, out_ready or hazard.
//     flush has priority over every other event.
//   - stall_cnt: +1 each cycle hazard is asserted, saturates at 2^CNT_W-1, never wraps.
//   - Decode:
//     - LUI: aluCtr=PASSB, regA=0.
//     - AUIPC: ADD.
//     - OP/OP-IMM: ALU op from funct3 and bit30; SUB only for OP; SRA for both.
//     - LOAD: regSelect=1, wen=1.
//     - STORE: dataWriteEnable=1, rd=0.
//     - BRANCH: wen=0, rd=0.
//   - Unused-field rule: U/J formats zero regA and regB; I format zeroes regB.
//   - Illegal opcode: registered as a valid op with all enables 0, branchCtr=0 and illegal=1.
//   - x0 as rd: registerWriteEnable is forced to 0.
//   - offset: sign bit is insn[31], extended to XLEN; B/J immediates have bit0 = 0.
// TESTING
//   1 reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=0, stall_cnt=0.
//   2 addi x1,x2,5 (0x00510093), pc=0x100 -> next cycle: aluCtr=0, regA=2, regB=0,
//     rd=1, offset=5, wen=1, pc_out=0x100.
//   3 load-use: ex_ld_valid=1, ex_ld_rd=5, insn add x6,x5,x7 (0x00728333) -> in_ready=0,
//     bubble, stall_cnt=1; drop ex_ld_valid -> accepted next cycle.
//   4 back-pressure: out_ready=0 for 4 cycles after beq x0,x0,8 (0x00000463)
//     -> outputs stable; branchCtr=8, offset=8, in_ready=0 throughout.
//   5 flush with FULL stage and in_valid=1 -> next cycle out_valid=0 and the incoming insn
//     is not captured.
//   6 illegal opcode 0x0000007F -> illegal=1, all enables 0; stall_cnt saturates
//     at 0xFFFF with CNT_W=16 under constant hazard.

Source files
------------

// File: rtl/id_stage_hs.sv
// RV32I decode stage with an ID/EX register, load-use stall, branch flush and stall counter.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: in_ready drops on flush, load-use hazard or a full register that EX is not draining.
module id_stage_hs #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_W      = 4,
    parameter int BR_W       = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           insn,
    input  logic [XLEN-1:0]       pc,
    input  logic                  flush,
    input  logic                  ex_ld_valid,
    input  logic [REG_ADDR_W-1:0] ex_ld_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  registerWriteEnable,
    output logic                  dataWriteEnable,
    output logic                  regSelect,
    output logic [BR_W-1:0]       branchCtr,
    output logic [ALU_W-1:0]      aluCtr,
    output logic [REG_ADDR_W-1:0] regA,
    output logic [REG_ADDR_W-1:0] regB,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       offset,
    output logic [XLEN-1:0]       pc_out,
    output logic                  illegal,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Pipeline register occupancy
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_SLL   = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_XOR   = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL   = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA   = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_OR    = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_PASSB = ALU_W'(10);

    // Branch control codes (conditional branches use {1, funct3})
    localparam logic [BR_W-1:0] BR_NONE = BR_W'(0);
    localparam logic [BR_W-1:0] BR_JAL  = BR_W'(1);
    localparam logic [BR_W-1:0] BR_JALR = BR_W'(2);

    // Immediate format selectors
    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Instruction fields
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_bit30;
    logic [REG_ADDR_W-1:0] w_rs1_fld;
    logic [REG_ADDR_W-1:0] w_rs2_fld;
    logic [REG_ADDR_W-1:0] w_rd_fld;

    assign w_opcode  = insn[6:0];
    assign w_funct3  = insn[14:12];
    assign w_bit30   = insn[30];
    assign w_rs1_fld = REG_ADDR_W'(insn[19:15]);
    assign w_rs2_fld = REG_ADDR_W'(insn[24:20]);
    assign w_rd_fld  = REG_ADDR_W'(insn[11:7]);

    // Decoded controls (combinational, before the ID/EX register)
    logic                  w_wen_raw;
    logic                  w_wen;
    logic                  w_dwe;
    logic                  w_rsel;
    logic [BR_W-1:0]       w_br;
    logic [ALU_W-1:0]      w_alu;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic                  w_use_rd;
    logic [2:0]            w_imm_sel;
    logic                  w_illegal;
    logic [REG_ADDR_W-1:0] w_rega;
    logic [REG_ADDR_W-1:0] w_regb;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [31:0]           w_imm32;
    logic [XLEN-1:0]       w_offset;

    // Handshake and hazard
    logic                  w_hazard;
    logic                  w_accept;
    logic                  r_state;

    // Registered ID/EX contents
    logic                  r_wen;
    logic                  r_dwe;
    logic                  r_rsel;
    logic [BR_W-1:0]       r_br;
    logic [ALU_W-1:0]      r_alu;
    logic [REG_ADDR_W-1:0] r_rega;
    logic [REG_ADDR_W-1:0] r_regb;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [XLEN-1:0]       r_offset;
    logic [XLEN-1:0]       r_pc;
    logic                  r_illegal;
    logic [CNT_W-1:0]      r_stall_cnt;

    // ALU op from funct3; bit30 selects SUB only for register-register ops, SRA for both
    function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [2:0] f3,
                                                         input logic       b30,
                                                         input logic       is_op);
        logic [ALU_W-1:0] op;
        case (f3)
            3'd0:    op = (is_op && b30) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = b30 ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Main decoder: per-opcode controls and which register fields the format uses
    always_comb begin
        w_wen_raw = 1'b0;
        w_dwe     = 1'b0;
        w_rsel    = 1'b0;
        w_br      = BR_NONE;
        w_alu     = ALU_ADD;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_imm_sel = IMM_NONE;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_wen_raw = 1'b1;
                w_use_rd  = 1'b1;
                w_alu     = ALU_PASSB;
                w_imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                w_wen_raw = 1'b1;
                w_use_rd  = 1'b1;
                w_alu     = ALU_ADD;
                w_imm_sel = IMM_U;
            end
            OPC_JAL: begin
                w_wen_raw = 1'b1;
                w_use_rd  = 1'b1;
                w_br      = BR_JAL;
                w_imm_sel = IMM_J;
            end
            OPC_JALR: begin
                w_wen_raw = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_br      = BR_JALR;
                w_imm_sel = IMM_I;
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_br      = BR_W'({1'b1, w_funct3});
                w_alu     = ALU_SUB;
                w_imm_sel = IMM_B;
            end
            OPC_LOAD: begin
                w_wen_raw = 1'b1;
                w_rsel    = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_imm_sel = IMM_I;
            end
            OPC_STORE: begin
                w_dwe     = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm_sel = IMM_S;
            end
            OPC_OPIMM: begin
                w_wen_raw = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_alu     = alu_from_funct3(w_funct3, w_bit30, 1'b0);
                w_imm_sel = IMM_I;
            end
            OPC_OP: begin
                w_wen_raw = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_alu     = alu_from_funct3(w_funct3, w_bit30, 1'b1);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Unused register fields read as x0 so they can never create a false hazard
    assign w_rega = w_use_rs1 ? w_rs1_fld : '0;
    assign w_regb = w_use_rs2 ? w_rs2_fld : '0;
    assign w_rd   = w_use_rd  ? w_rd_fld  : '0;
    // Writes to x0 are architectural no-ops
    assign w_wen  = w_wen_raw && (w_rd_fld != '0);

    // Immediate assembly per format; B/J scramble bits and force bit0 = 0
    always_comb begin
        w_imm32 = 32'd0;
        case (w_imm_sel)
            IMM_I:   w_imm32 = {{20{insn[31]}}, insn[31:20]};
            IMM_S:   w_imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B:   w_imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U:   w_imm32 = {insn[31:12], 12'd0};
            IMM_J:   w_imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Sign-extend from insn[31] up to the datapath width
    assign w_offset = XLEN'($signed(w_imm32));

    // Load-use: the producing load in EX has not returned data yet
    assign w_hazard = in_valid && ex_ld_valid && (ex_ld_rd != '0) &&
                      ((ex_ld_rd == w_rega) || (ex_ld_rd == w_regb));

    assign in_ready = rst && !flush && !w_hazard && ((r_state == ST_EMPTY) || out_ready);
    assign w_accept = in_valid && in_ready;

    // Occupancy FSM: flush dominates, then accept, then drain by EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state <= ST_FULL;
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    // ID/EX payload: loads only on accept, otherwise holds for a stalled EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen     <= 1'b0;
            r_dwe     <= 1'b0;
            r_rsel    <= 1'b0;
            r_br      <= '0;
            r_alu     <= '0;
            r_rega    <= '0;
            r_regb    <= '0;
            r_rd      <= '0;
            r_offset  <= '0;
            r_pc      <= '0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_wen     <= w_wen;
            r_dwe     <= w_dwe;
            r_rsel    <= w_rsel;
            r_br      <= w_br;
            r_alu     <= w_alu;
            r_rega    <= w_rega;
            r_regb    <= w_regb;
            r_rd      <= w_rd;
            r_offset  <= w_offset;
            r_pc      <= pc;
            r_illegal <= w_illegal;
        end
    end

    // Performance counter of hazard cycles, sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid           = (r_state == ST_FULL);
    assign registerWriteEnable = r_wen;
    assign dataWriteEnable     = r_dwe;
    assign regSelect           = r_rsel;
    assign branchCtr           = r_br;
    assign aluCtr              = r_alu;
    assign regA                = r_rega;
    assign regB                = r_regb;
    assign rd                  = r_rd;
    assign offset              = r_offset;
    assign pc_out              = r_pc;
    assign illegal             = r_illegal;
    assign stall_cnt           = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_hs.sv
// Directed bench for id_stage_hs: decode fields, load-use stall, backpressure, flush, saturation.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at that same point.
// Expected values are hand-derived from the RV32I encodings listed next to each vector.
module tb_id_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        flush;
    logic        ex_ld_valid;
    logic [4:0]  ex_ld_rd;
    logic        out_valid;
    logic        out_ready;
    logic        registerWriteEnable;
    logic        dataWriteEnable;
    logic        regSelect;
    logic [3:0]  branchCtr;
    logic [3:0]  aluCtr;
    logic [4:0]  regA;
    logic [4:0]  regB;
    logic [4:0]  rd;
    logic [31:0] offset;
    logic [31:0] pc_out;
    logic        illegal;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_stage_hs dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .insn                (insn),
        .pc                  (pc),
        .flush               (flush),
        .ex_ld_valid         (ex_ld_valid),
        .ex_ld_rd            (ex_ld_rd),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .registerWriteEnable (registerWriteEnable),
        .dataWriteEnable     (dataWriteEnable),
        .regSelect           (regSelect),
        .branchCtr           (branchCtr),
        .aluCtr              (aluCtr),
        .regA                (regA),
        .regB                (regB),
        .rd                  (rd),
        .offset              (offset),
        .pc_out              (pc_out),
        .illegal             (illegal),
        .stall_cnt           (stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle, then withdraw it
    task automatic send(input logic [31:0] i, input logic [31:0] p);
        insn     = i;
        pc       = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b1;
        insn        = 32'h0051_0093;
        pc          = 32'h100;
        flush       = 1'b0;
        ex_ld_valid = 1'b0;
        ex_ld_rd    = 5'd0;
        out_ready   = 1'b1;

        // 1: reset held 3 cycles with a valid instruction waiting
        #1 rst = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_offset", offset, 0);
        rst = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        // 2: addi x1,x2,5
        send(32'h0051_0093, 32'h100);
        check("addi_valid", out_valid, 1);
        check("addi_alu", aluCtr, 0);
        check("addi_regA", regA, 2);
        check("addi_regB", regB, 0);
        check("addi_rd", rd, 1);
        check("addi_offset", offset, 5);
        check("addi_wen", registerWriteEnable, 1);
        check("addi_pc", pc_out, 32'h100);

        // 3: load-use on rs1 (add x6,x5,x7 while EX loads x5), then on rs2
        insn        = 32'h0072_8333;
        pc          = 32'h104;
        in_valid    = 1'b1;
        ex_ld_valid = 1'b1;
        ex_ld_rd    = 5'd5;
        #1 check("lu_rs1_in_ready", in_ready, 0);
        tick();
        check("lu_bubble", out_valid, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        ex_ld_rd = 5'd7;
        #1 check("lu_rs2_in_ready", in_ready, 0);
        ex_ld_valid = 1'b0;
        #1 check("lu_clear_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("add_valid", out_valid, 1);
        check("add_regA", regA, 5);
        check("add_regB", regB, 7);
        check("add_rd", rd, 6);
        check("add_pc", pc_out, 32'h104);
        check("add_stall_cnt", stall_cnt, 1);

        // 4: beq x0,x0,8 then EX stalls for 4 cycles while IF offers addi
        send(32'h0000_0463, 32'h200);
        check("beq_br", branchCtr, 8);
        check("beq_offset", offset, 8);
        check("beq_wen", registerWriteEnable, 0);
        out_ready = 1'b0;
        insn      = 32'h0051_0093;
        pc        = 32'h300;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("bp_in_ready", in_ready, 0);
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_br", branchCtr, 8);
            check("bp_offset", offset, 8);
            check("bp_pc", pc_out, 32'h200);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_pc", pc_out, 32'h300);
        check("bp_release_valid", out_valid, 1);

        // 5: flush while FULL with lui x3,0x12345 on IF; EX also stalled
        flush     = 1'b1;
        out_ready = 1'b0;
        insn      = 32'h1234_51B7;
        pc        = 32'h400;
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_no_capture", pc_out, 32'h300);
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lui_alu", aluCtr, 10);
        check("lui_regA", regA, 0);
        check("lui_rd", rd, 3);
        check("lui_offset", offset, 32'h1234_5000);
        check("lui_pc", pc_out, 32'h400);

        // Further formats
        send(32'h0000_0013, 32'h500);             // addi x0,x0,0
        check("x0_wen", registerWriteEnable, 0);
        send(32'h4031_00B3, 32'h504);             // sub x1,x2,x3
        check("sub_alu", aluCtr, 1);
        send(32'h4031_5093, 32'h508);             // srai x1,x2,3
        check("srai_alu", aluCtr, 7);
        check("srai_regB", regB, 0);
        send(32'hFE51_2E23, 32'h50C);             // sw x5,-4(x2)
        check("sw_dwe", dataWriteEnable, 1);
        check("sw_wen", registerWriteEnable, 0);
        check("sw_rd", rd, 0);
        check("sw_regB", regB, 5);
        check("sw_offset", offset, 32'hFFFF_FFFC);
        send(32'h0080_A203, 32'h510);             // lw x4,8(x1)
        check("lw_regsel", regSelect, 1);
        check("lw_wen", registerWriteEnable, 1);
        check("lw_offset", offset, 8);
        send(32'hFF9F_F0EF, 32'h514);             // jal x1,-8
        check("jal_br", branchCtr, 1);
        check("jal_offset", offset, 32'hFFFF_FFF8);
        check("jal_regA", regA, 0);
        check("jal_rd", rd, 1);

        // 6: illegal opcode
        send(32'h0000_007F, 32'h600);
        check("ill_valid", out_valid, 1);
        check("ill_flag", illegal, 1);
        check("ill_wen", registerWriteEnable, 0);
        check("ill_dwe", dataWriteEnable, 0);
        check("ill_regsel", regSelect, 0);
        check("ill_br", branchCtr, 0);

        // 6: constant hazard drives stall_cnt from 1 into saturation
        insn        = 32'h0072_8333;
        pc          = 32'h700;
        in_valid    = 1'b1;
        ex_ld_valid = 1'b1;
        ex_ld_rd    = 5'd5;
        for (int i = 0; i < 65600; i++) begin
            tick();
            if (i == 9) check("sat_mid", stall_cnt, 11);
        end
        check("sat_max", stall_cnt, 16'hFFFF);
        check("sat_valid", out_valid, 0);
        check("sat_in_ready", in_ready, 0);
        tick();
        check("sat_no_wrap", stall_cnt, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
